// File: rtl/fixed_point_long_divider.sv
// Bit-serial restoring divider: Q = (dividend << FRAC_W) / divisor in a shared Q format,
// with valid/ready handshakes, signed/unsigned mode, saturation and zero/overflow flags.
module fixed_point_long_divider #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4,
    parameter bit SIGNED = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_quotient,
    output logic              o_div_by_zero,
    output logic              o_overflow
);

    localparam int N     = DATA_W + FRAC_W;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [N:0] ONE      = (N + 1)'(1);
    localparam logic [N:0] MAXP_MAG = SIGNED ? (ONE << (DATA_W - 1)) - ONE : (ONE << DATA_W) - ONE;
    localparam logic [N:0] MAXN_MAG = ONE << (DATA_W - 1);

    localparam logic [DATA_W-1:0] MAXP_Q = SIGNED ? {1'b0, {(DATA_W-1){1'b1}}} : {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] MAXN_Q = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W:0]   rem_q;
    logic [N-1:0]      quo_q;
    logic [N-1:0]      dvd_q;
    logic [DATA_W-1:0] dsr_q;
    logic              sign_q;

    logic [DATA_W:0]   rem_d;
    logic [N-1:0]      quo_d;
    logic [N-1:0]      dvd_d;
    logic [DATA_W+1:0] rem_shift;
    logic [DATA_W-1:0] fin_q;
    logic              fin_ov;

    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic              a_neg;
    logic              b_neg;

    assign a_neg = SIGNED & i_dividend[DATA_W-1];
    assign b_neg = SIGNED & i_divisor[DATA_W-1];
    // The unsigned DATA_W-bit magnitude of -2^(DATA_W-1) is exactly 2^(DATA_W-1).
    assign a_mag = a_neg ? -i_dividend : i_dividend;
    assign b_mag = b_neg ? -i_divisor  : i_divisor;

    // NOTE: every variable driven here gets a default first so no latch can be inferred.
    always_comb begin
        rem_shift = {rem_q, dvd_q[N-1]};
        rem_d     = (DATA_W + 1)'(rem_shift);
        quo_d     = quo_q << 1;
        dvd_d     = dvd_q << 1;
        fin_q     = '0;
        fin_ov    = 1'b0;

        if (rem_shift >= {2'b00, dsr_q}) begin
            rem_d = (DATA_W + 1)'(rem_shift - {2'b00, dsr_q});
            quo_d = (quo_q << 1) | N'(1);
        end

        if (!sign_q) begin
            if ({1'b0, quo_d} > MAXP_MAG) begin
                fin_q  = MAXP_Q;
                fin_ov = 1'b1;
            end else begin
                fin_q = quo_d[DATA_W-1:0];
            end
        end else if ({1'b0, quo_d} > MAXN_MAG) begin
            fin_q  = MAXN_Q;
            fin_ov = 1'b1;
        end else begin
            // Negating a zero magnitude stays zero, so no negative zero appears.
            fin_q = -quo_d[DATA_W-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvd_q         <= '0;
            dsr_q         <= '0;
            sign_q        <= 1'b0;
            o_ready       <= 1'b1;
            o_valid       <= 1'b0;
            o_quotient    <= '0;
            o_div_by_zero <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        o_ready       <= 1'b0;
                        sign_q        <= a_neg ^ b_neg;
                        dsr_q         <= b_mag;
                        dvd_q         <= N'(a_mag) << FRAC_W;
                        rem_q         <= '0;
                        quo_q         <= '0;
                        cnt_q         <= CNT_W'(N);
                        o_overflow    <= 1'b0;
                        o_div_by_zero <= (i_divisor == '0);
                        if (i_divisor == '0) begin
                            state_q    <= DONE;
                            o_valid    <= 1'b1;
                            o_quotient <= a_neg ? MAXN_Q : MAXP_Q;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    // The last iteration saturates its own quotient bit straight into the outputs.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q    <= DONE;
                        o_valid    <= 1'b1;
                        o_quotient <= fin_q;
                        o_overflow <= fin_ov;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state_q <= IDLE;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
